// File: rtl/program_counter_stack_pkg.sv
// program_counter_stack_pkg
//   Shared definitions for the program counter and its return-address stack:
//   the decoded command type and the one-hot command decoder.
//   Raw command bits are packed into cmd_req_t in the order load/branch/call/ret.
package program_counter_stack_pkg;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_BRANCH,
        CMD_CALL,
        CMD_RET,
        CMD_CONFLICT
    } cmd_e;

    typedef struct packed {
        logic load;
        logic branch;
        logic call;
        logic ret;
    } cmd_req_t;

    // Exactly one command bit selects that command. More than one bit set is a
    // fault: PC and sp hold, and the sticky error flag is raised.
    function automatic cmd_e decode_cmd(input cmd_req_t r);
        case (r)
            4'b0000: return CMD_NONE;
            4'b1000: return CMD_LOAD;
            4'b0100: return CMD_BRANCH;
            4'b0010: return CMD_CALL;
            4'b0001: return CMD_RET;
            default: return CMD_CONFLICT;
        endcase
    endfunction

endpackage

// File: rtl/program_counter_stack_return_stack.sv
// return_stack
//   Synchronous LIFO of return addresses.
//   Ports:
//     clock     - posedge clock
//     notReset  - synchronous active-low reset (empties the stack)
//     push/pop  - push din / discard top. The parent never pushes when full
//                 or pops when empty.
//     din       - value to push
//     dout      - current top entry (combinational; meaningless when empty)
//     full      - sp == STACK_DEPTH
//     empty     - sp == 0
//     sp        - entry count
module return_stack
    import program_counter_stack_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int STACK_DEPTH = 8,
    parameter int SP_WIDTH    = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  notReset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [SP_WIDTH-1:0]   sp
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [STACK_DEPTH];
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;

    // sp points at the next free slot; the top lives at sp-1.
    assign wr_idx = IDX_W'(sp);
    assign rd_idx = IDX_W'(sp - SP_WIDTH'(1));
    assign dout   = mem[rd_idx];
    assign full   = (sp == SP_WIDTH'(STACK_DEPTH));
    assign empty  = (sp == '0);

    always_ff @(posedge clock) begin
        if (!notReset) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + SP_WIDTH'(1);
        end else if (pop) begin
            sp <= sp - SP_WIDTH'(1);
        end
    end

    // Storage needs no reset: entries above sp are never read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// program_counter_stack
//   Word-addressed program counter with relative branch and a hardware
//   return-address stack. Bus addresses are byte addresses; the PC holds
//   word addresses (byte address >> ADDR_SHIFT).
//   Ports:
//     clock, notReset     - posedge clock, synchronous active-low reset
//     notLoad             - active-low absolute jump to in >> ADDR_SHIFT
//     notOE               - active-low bus drive enable for out
//     inc                 - advance one word when no other command is active
//     branch / offset     - PC += signed word offset
//     call / in           - push PC+1, jump to in >> ADDR_SHIFT
//     ret                 - pop return address into PC
//     out                 - PC << ADDR_SHIFT on the bus, high-Z when notOE=1
//     stack_full/empty    - return-stack occupancy
//     stack_error         - sticky fault: conflict, overflow or underflow
//     content             - raw word-address PC for monitors
module program_counter_stack
    import program_counter_stack_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_SHIFT  = 1,
    parameter int STACK_DEPTH = 8,
    parameter int SP_WIDTH    = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  notReset,
    input  logic                  notLoad,
    input  logic                  notOE,
    input  logic                  inc,
    input  logic                  branch,
    input  logic                  call,
    input  logic                  ret,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic [DATA_WIDTH-1:0] offset,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  stack_full,
    output logic                  stack_empty,
    output logic                  stack_error,
    output logic [DATA_WIDTH-1:0] content
);

    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_inc;
    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] ret_addr;
    logic [SP_WIDTH-1:0]   sp;
    logic                  push;
    logic                  pop;
    cmd_req_t              req;
    cmd_e                  cmd;

    assign req    = '{load: !notLoad, branch: branch, call: call, ret: ret};
    assign cmd    = decode_cmd(req);
    assign pc_inc = pc + DATA_WIDTH'(1);
    assign target = in >> ADDR_SHIFT;

    // Stack operations are gated here so the LIFO never sees an overflow or
    // underflow; the fault is recorded in stack_error instead.
    assign push = (cmd == CMD_CALL) && (sp != SP_WIDTH'(STACK_DEPTH));
    assign pop  = (cmd == CMD_RET) && !stack_empty;

    return_stack #(
        .DATA_WIDTH (DATA_WIDTH),
        .STACK_DEPTH(STACK_DEPTH),
        .SP_WIDTH   (SP_WIDTH)
    ) u_stack (
        .clock   (clock),
        .notReset(notReset),
        .push    (push),
        .pop     (pop),
        .din     (pc_inc),
        .dout    (ret_addr),
        .full    (stack_full),
        .empty   (stack_empty),
        .sp      (sp)
    );

    always_ff @(posedge clock) begin
        if (!notReset) begin
            pc          <= '0;
            stack_error <= 1'b0;
        end else begin
            case (cmd)
                CMD_LOAD:   pc <= target;
                CMD_BRANCH: pc <= pc + offset;
                CMD_CALL: begin
                    if (push) pc <= target;
                    else      stack_error <= 1'b1;
                end
                CMD_RET: begin
                    if (pop) pc <= ret_addr;
                    else     stack_error <= 1'b1;
                end
                CMD_CONFLICT: stack_error <= 1'b1;
                default: begin
                    if (inc) pc <= pc_inc;
                end
            endcase
        end
    end

    assign content = pc;
    assign out     = notOE ? {DATA_WIDTH{1'bz}} : (pc << ADDR_SHIFT);

endmodule
